// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write-port arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int BEAT_COUNT_W = 16;

  // Width of an index into n items; never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, searching last+1, last+2, ... with wrap
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any) begin
        cand = IDX_W'((int'(last) + k) % NUM_REQ);
        if (req[cand]) begin
          any         = 1'b1;
          grant[cand] = 1'b1;
          idx         = cand;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_full,
  input  logic                          fifo_overflow,
  output logic [clog2w(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic                          ovf_err,
  output logic [BEAT_COUNT_W-1:0]       beat_count
);

  localparam int IDX_W = clog2w(NUM_REQ);
  localparam int CNT_W = clog2w(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  arb_state_t               state_q, state_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]         last_q, last_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BEAT_COUNT_W-1:0]  beat_count_q;
  logic                     ovf_err_q;
  logic                     rel;

  logic [NUM_REQ-1:0]       pick_grant;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_any;
  logic [IDX_W-1:0]         wdata_sel;
  logic [DATA_WIDTH-1:0]    lane [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Full and reset gate the accept in the same cycle so the FIFO never sees a write while full.
  always_comb begin
    req_ack = '0;
    if (state_q == BURST && !fifo_full && !rst) begin
      req_ack = grant_q & req_valid;
    end
  end

  assign fifo_wr    = |req_ack;
  assign wdata_sel  = (state_q == BURST) ? owner_q : {IDX_W{1'b0}};
  assign fifo_wdata = lane[wdata_sel];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          grant_d = pick_grant;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (!req_valid[owner_q]) begin
          rel = 1'b1;
        end else if (fifo_wr) begin
          if (cnt_q == LAST_BEAT) begin
            rel = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rel) begin
      last_d  = owner_q;
      grant_d = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= LAST_INIT;
      owner_q      <= '0;
      cnt_q        <= '0;
      beat_count_q <= '0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (fifo_wr) begin
        beat_count_q <= beat_count_q + 1'b1;
      end
      if (fifo_overflow) begin
        ovf_err_q <= 1'b1;
      end
    end
  end

  assign owner      = owner_q;
  assign busy       = (state_q == BURST);
  assign ovf_err    = ovf_err_q;
  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - bench for fifo_wr_arbiter: directed scenarios plus random traffic against a model
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic          fifo_full = 1'b0;
  logic          fifo_overflow = 1'b0;

  logic [N-1:0]  ack_o  [2];
  logic          wr_o   [2];
  logic [DW-1:0] wd_o   [2];
  logic [1:0]    own_o  [2];
  logic          busy_o [2];
  logic          ovf_o  [2];
  logic [15:0]   bc_o   [2];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut4 (
    .wr_clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(ack_o[0]), .fifo_wr(wr_o[0]), .fifo_wdata(wd_o[0]),
    .fifo_full(fifo_full), .fifo_overflow(fifo_overflow),
    .owner(own_o[0]), .busy(busy_o[0]), .ovf_err(ovf_o[0]), .beat_count(bc_o[0])
  );

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1)) u_dut1 (
    .wr_clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(ack_o[1]), .fifo_wr(wr_o[1]), .fifo_wdata(wd_o[1]),
    .fifo_full(fifo_full), .fifo_overflow(fifo_overflow),
    .owner(own_o[1]), .busy(busy_o[1]), .ovf_err(ovf_o[1]), .beat_count(bc_o[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Behavioural model, one per instance: who holds the port, beats sent this burst, last winner.
  bit m_busy  [2];
  int m_owner [2];
  int m_cnt   [2];
  int m_last  [2];
  int m_beats [2];
  bit m_ovf   [2];
  int maxb    [2] = '{4, 1};

  logic [N-1:0] ack_s [2];
  logic         wr_s  [2];
  logic [7:0]   wdq0 [$];
  logic [7:0]   wdq1 [$];
  int           wcy1 [$];

  function automatic logic [7:0] lane(input int i);
    return req_data[i*DW +: DW];
  endfunction

  task automatic set_lane(input int i, input logic [7:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int m);
    m_busy[m]  = 1'b0;
    m_owner[m] = 0;
    m_cnt[m]   = 0;
    m_last[m]  = N - 1;
    m_beats[m] = 0;
    m_ovf[m]   = 1'b0;
  endtask

  function automatic bit model_acc(input int m);
    return !rst && m_busy[m] && req_valid[m_owner[m]] && !fifo_full;
  endfunction

  task automatic compare_model(input int m);
    bit acc;
    logic [N-1:0] ea;
    acc = model_acc(m);
    ea  = acc ? (N'(1) << m_owner[m]) : '0;
    chk($sformatf("u%0d.req_ack", m), 32'(ack_o[m]), 32'(ea));
    chk($sformatf("u%0d.fifo_wr", m), 32'(wr_o[m]), 32'(acc));
    chk($sformatf("u%0d.fifo_wdata", m), 32'(wd_o[m]), 32'(m_busy[m] ? lane(m_owner[m]) : lane(0)));
    chk($sformatf("u%0d.busy", m), 32'(busy_o[m]), 32'(m_busy[m]));
    if (m_busy[m]) chk($sformatf("u%0d.owner", m), 32'(own_o[m]), 32'(m_owner[m]));
    chk($sformatf("u%0d.beat_count", m), 32'(bc_o[m]), 32'(m_beats[m] % 65536));
    chk($sformatf("u%0d.ovf_err", m), 32'(ovf_o[m]), 32'(m_ovf[m]));
  endtask

  task automatic model_next(input int m);
    bit acc;
    int c;
    acc = model_acc(m);
    if (rst) begin
      model_reset(m);
    end else begin
      if (fifo_overflow) m_ovf[m] = 1'b1;
      if (acc) m_beats[m] = (m_beats[m] + 1) % 65536;
      if (!m_busy[m]) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last[m] + k) % N;
          if (req_valid[c]) begin
            m_busy[m]  = 1'b1;
            m_owner[m] = c;
            m_cnt[m]   = 0;
            break;
          end
        end
      end else if (!req_valid[m_owner[m]]) begin
        m_last[m] = m_owner[m];
        m_busy[m] = 1'b0;
      end else if (acc) begin
        m_cnt[m]++;
        if (m_cnt[m] == maxb[m]) begin
          m_last[m] = m_owner[m];
          m_busy[m] = 1'b0;
        end
      end
    end
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, return just after the next edge.
  task automatic step();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      compare_model(m);
      ack_s[m] = ack_o[m];
      wr_s[m]  = wr_o[m];
    end
    if (wr_o[0]) wdq0.push_back(wd_o[0]);
    if (wr_o[1]) begin
      wdq1.push_back(wd_o[1]);
      wcy1.push_back(cyc);
    end
    for (int m = 0; m < 2; m++) model_next(m);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    fifo_overflow = 1'b0;
    step();
    step();
    rst = 1'b0;
    wdq0.delete();
    wdq1.delete();
    wcy1.delete();
    cyc = 0;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    #1;
    do_reset();

    chk("reset.busy", 32'(busy_o[0]), 32'd0);
    chk("reset.beat_count", 32'(bc_o[0]), 32'd0);
    chk("reset.ovf_err", 32'(ovf_o[0]), 32'd0);
    chk("reset.owner", 32'(own_o[0]), 32'd0);
    chk("reset.fifo_wr", 32'(wr_o[0]), 32'd0);

    // Reset priority and lane data mux: all requesting, lane i carries A0+i.
    for (int i = 0; i < N; i++) set_lane(i, 8'hA0 + 8'(i));
    req_valid = 4'b1111;
    repeat (21) step();
    chk("prio.beat_count", 32'(bc_o[0]), 32'd16);
    chk("prio.busy_again", 32'(busy_o[0]), 32'd1);
    chk("prio.owner_wraps", 32'(own_o[0]), 32'd0);
    chk("prio.writes", 32'(wdq0.size()), 32'd16);
    for (int j = 0; j < 16 && j < wdq0.size(); j++)
      chk("prio.seq", 32'(wdq0[j]), 32'(8'hA0 + 8'(j / 4)));
    chk("mux.beat_count", 32'(bc_o[1]), 32'd10);
    chk("mux.writes", 32'(wdq1.size()), 32'd10);
    for (int j = 0; j < 5 && j < wdq1.size(); j++)
      chk("mux.seq", 32'(wdq1[j]), 32'(8'hA0 + 8'(j % 4)));
    for (int j = 1; j < 5 && j < wcy1.size(); j++)
      chk("mux.gap", 32'(wcy1[j] - wcy1[j-1]), 32'd2);

    // Early release: req2 sends two beats then drops valid.
    do_reset();
    set_lane(2, 8'h55);
    req_valid = 4'b0100;
    repeat (3) step();
    req_valid = 4'b0000;
    step();
    chk("early.busy", 32'(busy_o[0]), 32'd0);
    chk("early.beats", 32'(bc_o[0]), 32'd2);
    chk("early.writes", 32'(wdq0.size()), 32'd2);
    req_valid = 4'b1100;
    step();
    chk("early.next_busy", 32'(busy_o[0]), 32'd1);
    chk("early.next_owner", 32'(own_o[0]), 32'd3);

    // Stall: full held for five cycles after the first beat.
    do_reset();
    set_lane(0, 8'h11);
    req_valid = 4'b0001;
    step();
    step();
    chk("stall.first", 32'(wdq0.size()), 32'd1);
    set_lane(0, 8'h22);
    fifo_full = 1'b1;
    repeat (5) step();
    chk("stall.no_write", 32'(wdq0.size()), 32'd1);
    chk("stall.held", 32'(busy_o[0]), 32'd1);
    chk("stall.owner", 32'(own_o[0]), 32'd0);
    fifo_full = 1'b0;
    step();
    set_lane(0, 8'h33);
    step();
    set_lane(0, 8'h44);
    step();
    chk("stall.release", 32'(busy_o[0]), 32'd0);
    chk("stall.writes", 32'(wdq0.size()), 32'd4);
    for (int j = 0; j < 4 && j < wdq0.size(); j++)
      chk("stall.data", 32'(wdq0[j]), 32'(8'h11 * (j + 1)));

    // Reset during beat 2 of req1's burst.
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, 8'hA0 + 8'(i));
    req_valid = 4'b1111;
    repeat (7) step();
    chk("rstmid.owner1", 32'(own_o[0]), 32'd1);
    rst = 1'b1;
    step();
    chk("rstmid.fifo_wr", 32'(wr_s[0]), 32'd0);
    chk("rstmid.ack", 32'(ack_s[0]), 32'd0);
    rst = 1'b0;
    chk("rstmid.busy", 32'(busy_o[0]), 32'd0);
    chk("rstmid.beat_count", 32'(bc_o[0]), 32'd0);
    step();
    chk("rstmid.regrant_busy", 32'(busy_o[0]), 32'd1);
    chk("rstmid.regrant_owner", 32'(own_o[0]), 32'd0);

    // Overflow flag is sticky until reset.
    fifo_overflow = 1'b1;
    step();
    fifo_overflow = 1'b0;
    chk("ovf.set", 32'(ovf_o[0]), 32'd1);
    repeat (3) step();
    chk("ovf.held", 32'(ovf_o[0]), 32'd1);
    chk("ovf.held_u1", 32'(ovf_o[1]), 32'd1);
    do_reset();
    chk("ovf.cleared", 32'(ovf_o[0]), 32'd0);

    // Random traffic: producers hold beats until acked by the MAX_BURST=4 instance.
    for (int i = 0; i < N; i++) ack_s[0][i] = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      fifo_full     = ($urandom % 4) == 0;
      fifo_overflow = ($urandom % 1500) == 0;
      rst           = ($urandom % 500) == 0;
      for (int i = 0; i < N; i++) begin
        if (ack_s[0][i] || !req_valid[i]) begin
          req_valid[i] = ($urandom % 4) != 0;
          set_lane(i, 8'($urandom));
        end
      end
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
